dsp_pwr_seq: RTL and testbench
==============================

# dsp_pwr_seq

Single-clock power/reset sequencer for the TMS320VC5509A DSP on the CPLD. It drives the DSP supply enable (`pwron`) and the DSP reset release (`dsp_rst_n`) with programmable cycle delays, and watches the regulator power-good input. It shuts the DSP down in reverse order on request or fault, and retries a bounded number of times. It replaces free-running external-edge timing with counted delays; `pwron` always precedes reset release.

## Interface
Parameters:
- `CNT_W`, 20: width of the shared delay down-counter.
- `T_PWRON`, 1000: wait cycles from accepted `en` to `pwron` assertion.
- `T_PG_TO`, 50000: maximum cycles in PG_WAIT for synchronized `pgood`.
- `T_RST`, 20000: cycles `pgood` must hold before `dsp_rst_n` releases.
- `T_OFF`, 500: cycles between `dsp_rst_n` drop and `pwron` drop.
- `MAX_RETRY`, 3: automatic restart attempts after a fault (0 to 7).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `en`  in  1  level power-up request; synchronous to `clk`.
- `pgood`  in  1  regulator power-good; asynchronous, 2-flop synchronized inside.
- `pwron`  out  1  DSP supply enable, registered.
- `dsp_rst_n`  out  1  DSP reset; 1 = DSP running. Registered.
- `ready`  out  1  high only in RUN.
- `fault`  out  1  high only in FAULT.
- `state`  out  3  current state encoding, for debug.

## Operation
- States: OFF(0), PWR_WAIT(1), PG_WAIT(2), RST_HOLD(3), RUN(4), SHUTDOWN(5), FAULT(6).
- The counter loads on state entry and decrements each cycle. A "done" condition is `cnt==0`. A parameter value of 0 means leave after 1 cycle.
- OFF: `en`=1 → PWR_WAIT, load T_PWRON.
- PWR_WAIT: `en`=0 → OFF. Done → PG_WAIT, load T_PG_TO; `pwron` rises.
- PG_WAIT: synced `pgood`=1 → RST_HOLD, load T_RST. Done without `pgood` → SHUTDOWN, fault event. `en`=0 → SHUTDOWN, no fault.
- RST_HOLD: `pgood`=0 → SHUTDOWN, fault event. Done → RUN; `dsp_rst_n` rises.
- RUN: `pgood`=0 → SHUTDOWN, fault event. `en`=0 → SHUTDOWN, no fault.
- SHUTDOWN: on entry `dsp_rst_n`=0 and counter loads T_OFF. When done, `pwron`=0 and the next state is chosen:
  - no fault event pending → OFF;
  - fault pending and `retry_cnt` < MAX_RETRY and `en`=1 → PWR_WAIT, `retry_cnt`+1;
  - otherwise → FAULT.
- FAULT: `pwron`=0 and `dsp_rst_n`=0. Exits to OFF only when `en`=0.
- `retry_cnt` (3 bits) clears on entering RUN and on entering OFF.
- Simultaneous `en` drop and `pgood` loss → treated as a fault event; the retry path is then blocked by `en`=0, so the block ends in FAULT.
- Invariant: `dsp_rst_n`=1 implies `pwron`=1.

## Timing
- Reset values: state=OFF, `pwron`=0, `dsp_rst_n`=0, `ready`=0, `fault`=0, counter=0, `retry_cnt`=0, sync flops=0.
- All outputs are registered and change on the same edge as the state register.
- `en` sampled high at edge k → PWR_WAIT at k. `pwron`=1 at edge k+T_PWRON+1.
- `pgood` input rise → visible to the FSM 2 edges later. The next edge enters RST_HOLD.
- RST_HOLD entry at edge m → `dsp_rst_n`=1 and `ready`=1 at edge m+T_RST+1.
- SHUTDOWN entry at edge s: `dsp_rst_n`=0 and `ready`=0 at s. `pwron`=0 at s+T_OFF+1.
- `pgood` glitches shorter than 1 cycle may be missed. This is acceptable.
- Reset asserted mid-sequence forces all outputs low immediately (asynchronously), including `pwron`.

## Structure
- Shared package `dsp_pwr_pkg`: state encoding constants, default delay constants.
- Sub-module `sync2` (2-flop synchronizer with async active-low reset) for `pgood`. The FSM, counter and retry logic stay in `dsp_pwr_seq`.

## Test plan
Common parameters: T_PWRON=4, T_PG_TO=16, T_RST=8, T_OFF=3, MAX_RETRY=2.
- Normal bring-up: `en`=1 at edge 10, `pgood` rises 2 cycles after `pwron` → `pwron`=1 at edge 15; `dsp_rst_n`=1 and `ready`=1 exactly 9 edges after RST_HOLD entry.
- Orderly shutdown: `en`=0 in RUN → `dsp_rst_n`=0 next edge; `pwron`=0 4 edges later; state OFF; `fault`=0.
- Power-good timeout: `pgood` held 0 → SHUTDOWN 17 edges after PG_WAIT entry. Two retries occur (`pwron` pulses 3 times in total), then FAULT with `fault`=1. Dropping `en` returns to OFF.
- Brown-out in RUN: `pgood` drops for 5 cycles → `dsp_rst_n` falls first, `pwron` falls 4 edges later, one retry reaches RUN, `retry_cnt` returns to 0.
- Abort during PWR_WAIT: `en` drops at counter=2 → OFF, `pwron` never asserts.
- Async reset during RST_HOLD and during RUN → all outputs 0 without a clock edge; the sequence restarts from OFF after release.

Source files
------------

// File: rtl/dsp_pwr_seq_pkg.sv
// Shared definitions for the DSP power/reset sequencer: state encoding,
// default delays and a helper that tells which states keep the supply on.
package dsp_pwr_pkg;

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_PWR_WAIT = 3'd1,
    S_PG_WAIT  = 3'd2,
    S_RST_HOLD = 3'd3,
    S_RUN      = 3'd4,
    S_SHUTDOWN = 3'd5,
    S_FAULT    = 3'd6
  } state_t;

  localparam int DEF_CNT_W     = 20;
  localparam int DEF_T_PWRON   = 1000;
  localparam int DEF_T_PG_TO   = 50000;
  localparam int DEF_T_RST     = 20000;
  localparam int DEF_T_OFF     = 500;
  localparam int DEF_MAX_RETRY = 3;

  // SHUTDOWN keeps the rail up until its off-delay expires.
  function automatic logic supply_on(input state_t s);
    return (s == S_PG_WAIT) || (s == S_RST_HOLD) || (s == S_RUN) || (s == S_SHUTDOWN);
  endfunction

endpackage

// File: rtl/dsp_pwr_seq_sync2.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/dsp_pwr_seq.sv
// Power/reset sequencer for the C5509A: counted delays between supply enable,
// power-good and reset release, reverse-order shutdown and bounded retries.
module dsp_pwr_seq
  import dsp_pwr_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int T_PWRON   = DEF_T_PWRON,
  parameter int T_PG_TO   = DEF_T_PG_TO,
  parameter int T_RST     = DEF_T_RST,
  parameter int T_OFF     = DEF_T_OFF,
  parameter int MAX_RETRY = DEF_MAX_RETRY
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       pgood,
  output logic       pwron,
  output logic       dsp_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [2:0] state
);

  logic             pgood_s;
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       retry_cnt_reg, retry_cnt_next;
  logic             fault_pend_reg, fault_pend_next;
  logic             fault_evt, retry_inc, cnt_done, entering;
  logic             pwron_reg, dsp_rst_n_reg, ready_reg, fault_reg;
  logic             pwron_next, dsp_rst_n_next, ready_next, fault_next;

  sync2 u_pgood_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pgood),
    .q     (pgood_s)
  );

  assign cnt_done = (cnt_reg == '0);
  assign entering = (state_next != state_reg);

  // State register; outputs are registered alongside it so they move on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_OFF;
      pwron_reg     <= 1'b0;
      dsp_rst_n_reg <= 1'b0;
      ready_reg     <= 1'b0;
      fault_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pwron_reg     <= pwron_next;
      dsp_rst_n_reg <= dsp_rst_n_next;
      ready_reg     <= ready_next;
      fault_reg     <= fault_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    fault_evt  = 1'b0;
    retry_inc  = 1'b0;
    case (state_reg)
      S_OFF: begin
        if (en) state_next = S_PWR_WAIT;
      end
      S_PWR_WAIT: begin
        if (!en)           state_next = S_OFF;
        else if (cnt_done) state_next = S_PG_WAIT;
      end
      S_PG_WAIT: begin
        if (pgood_s) begin
          state_next = S_RST_HOLD;
        end else if (cnt_done) begin
          state_next = S_SHUTDOWN;
          fault_evt  = 1'b1;
        end else if (!en) begin
          state_next = S_SHUTDOWN;
        end
      end
      S_RST_HOLD: begin
        // Loss of power-good wins over a request drop so a brown-out is never masked.
        if (!pgood_s) begin
          state_next = S_SHUTDOWN;
          fault_evt  = 1'b1;
        end else if (!en) begin
          state_next = S_SHUTDOWN;
        end else if (cnt_done) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (!pgood_s) begin
          state_next = S_SHUTDOWN;
          fault_evt  = 1'b1;
        end else if (!en) begin
          state_next = S_SHUTDOWN;
        end
      end
      S_SHUTDOWN: begin
        if (cnt_done) begin
          if (!fault_pend_reg) begin
            state_next = S_OFF;
          end else if ((int'(retry_cnt_reg) < MAX_RETRY) && en) begin
            state_next = S_PWR_WAIT;
            retry_inc  = 1'b1;
          end else begin
            state_next = S_FAULT;
          end
        end
      end
      S_FAULT: begin
        if (!en) state_next = S_OFF;
      end
      default: state_next = S_OFF;
    endcase
  end

  always_comb begin
    pwron_next     = supply_on(state_next);
    dsp_rst_n_next = (state_next == S_RUN);
    ready_next     = (state_next == S_RUN);
    fault_next     = (state_next == S_FAULT);
  end

  // Shared delay counter, fault latch and retry counter.
  always_comb begin
    cnt_next        = cnt_reg;
    fault_pend_next = fault_pend_reg;
    retry_cnt_next  = retry_cnt_reg;
    if (entering) begin
      case (state_next)
        S_PWR_WAIT: cnt_next = CNT_W'(T_PWRON);
        S_PG_WAIT:  cnt_next = CNT_W'(T_PG_TO);
        S_RST_HOLD: cnt_next = CNT_W'(T_RST);
        S_SHUTDOWN: cnt_next = CNT_W'(T_OFF);
        default:    cnt_next = '0;
      endcase
    end else if (!cnt_done) begin
      cnt_next = cnt_reg - CNT_W'(1);
    end

    if (entering && (state_next == S_SHUTDOWN))   fault_pend_next = fault_evt;
    else if (entering && (state_reg == S_SHUTDOWN)) fault_pend_next = 1'b0;

    if (entering && ((state_next == S_RUN) || (state_next == S_OFF))) retry_cnt_next = 3'd0;
    else if (retry_inc)                                               retry_cnt_next = retry_cnt_reg + 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg        <= '0;
      retry_cnt_reg  <= 3'd0;
      fault_pend_reg <= 1'b0;
    end else begin
      cnt_reg        <= cnt_next;
      retry_cnt_reg  <= retry_cnt_next;
      fault_pend_reg <= fault_pend_next;
    end
  end

  assign pwron     = pwron_reg;
  assign dsp_rst_n = dsp_rst_n_reg;
  assign ready     = ready_reg;
  assign fault     = fault_reg;
  assign state     = state_reg;

endmodule

// File: tb/tb_dsp_pwr_seq.sv
// Bench for dsp_pwr_seq: step table plus hand sequences; expectations are queued
// with their due cycle and compared by a monitor just after each rising edge.
module tb_dsp_pwr_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       pgood = 1'b0;
  logic       pwron, dsp_rst_n, ready, fault;
  logic [2:0] state;

  dsp_pwr_seq #(
    .CNT_W(20), .T_PWRON(4), .T_PG_TO(16), .T_RST(8), .T_OFF(3), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pgood(pgood),
    .pwron(pwron), .dsp_rst_n(dsp_rst_n), .ready(ready), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       pg;
    int         n;
    logic [2:0] st;
    logic       pw, rn, rdy, flt;
    int         rc;
  } vec_t;

  typedef struct {
    int         at;
    int         id;
    logic [2:0] st;
    logic       pw, rn, rdy, flt;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t mk(input logic e, input logic p, input int n, input logic [2:0] st,
                              input logic pw, input logic rn, input logic rdy, input logic flt,
                              input int rc);
    vec_t v;
    v.en = e; v.pg = p; v.n = n; v.st = st;
    v.pw = pw; v.rn = rn; v.rdy = rdy; v.flt = flt; v.rc = rc;
    return v;
  endfunction

  task automatic compare(input string tag, input logic [2:0] st, input logic pw,
                         input logic rn, input logic rdy, input logic flt);
    n_checks++;
    if (state !== st || pwron !== pw || dsp_rst_n !== rn || ready !== rdy || fault !== flt) begin
      n_fail++;
      $display("FAIL %s t=%0t: state/pwron/dsp_rst_n/ready/fault got %0d/%b/%b/%b/%b expected %0d/%b/%b/%b/%b",
               tag, $time, state, pwron, dsp_rst_n, ready, fault, st, pw, rn, rdy, flt);
    end else begin
      $display("ok   %s t=%0t: state=%0d pwron=%b dsp_rst_n=%b ready=%b fault=%b",
               tag, $time, state, pwron, dsp_rst_n, ready, fault);
    end
  endtask

  task automatic check_retry(input string tag, input int want);
    n_checks++;
    if (int'(dut.retry_cnt_reg) != want) begin
      n_fail++;
      $display("FAIL %s: retry_cnt got %0d expected %0d", tag, dut.retry_cnt_reg, want);
    end else begin
      $display("ok   %s: retry_cnt=%0d", tag, dut.retry_cnt_reg);
    end
  endtask

  // Drive one step at a falling edge and schedule the outputs expected n rising edges later.
  task automatic step(input int id, input vec_t v);
    exp_t e;
    en    = v.en;
    pgood = v.pg;
    e.at = cyc + v.n; e.id = id; e.st = v.st;
    e.pw = v.pw; e.rn = v.rn; e.rdy = v.rdy; e.flt = v.flt;
    sb.push_back(e);
    repeat (v.n) @(negedge clk);
  endtask

  always begin
    @(posedge clk);
    #1;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      compare($sformatf("step%0d", e.id), e.st, e.pw, e.rn, e.rdy, e.flt);
    end
    if (rst_n) begin
      n_checks++;
      if (dsp_rst_n && !pwron) begin
        n_fail++;
        $display("FAIL invariant t=%0t: dsp_rst_n got %b with pwron %b, required pwron=1", $time, dsp_rst_n, pwron);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, queue holds %0d", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    // Normal bring-up
    vecs.push_back(mk(1, 0, 1,  3'd1, 0, 0, 0, 0, -1));
    vecs.push_back(mk(1, 0, 4,  3'd1, 0, 0, 0, 0, -1));
    vecs.push_back(mk(1, 0, 1,  3'd2, 1, 0, 0, 0, -1));
    vecs.push_back(mk(1, 0, 2,  3'd2, 1, 0, 0, 0, -1));
    vecs.push_back(mk(1, 1, 2,  3'd2, 1, 0, 0, 0, -1));
    vecs.push_back(mk(1, 1, 1,  3'd3, 1, 0, 0, 0, -1));
    vecs.push_back(mk(1, 1, 8,  3'd3, 1, 0, 0, 0, -1));
    vecs.push_back(mk(1, 1, 1,  3'd4, 1, 1, 1, 0, 0));
    vecs.push_back(mk(1, 1, 5,  3'd4, 1, 1, 1, 0, -1));
    // Orderly shutdown
    vecs.push_back(mk(0, 1, 1,  3'd5, 1, 0, 0, 0, -1));
    vecs.push_back(mk(0, 1, 3,  3'd5, 1, 0, 0, 0, -1));
    vecs.push_back(mk(0, 1, 1,  3'd0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3,  3'd0, 0, 0, 0, 0, -1));
    // Power-good timeout with two retries then FAULT
    vecs.push_back(mk(1, 0, 6,  3'd2, 1, 0, 0, 0, -1));
    vecs.push_back(mk(1, 0, 16, 3'd2, 1, 0, 0, 0, -1));
    vecs.push_back(mk(1, 0, 1,  3'd5, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 4,  3'd1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 5,  3'd2, 1, 0, 0, 0, -1));
    vecs.push_back(mk(1, 0, 17, 3'd5, 1, 0, 0, 0, -1));
    vecs.push_back(mk(1, 0, 4,  3'd1, 0, 0, 0, 0, 2));
    vecs.push_back(mk(1, 0, 5,  3'd2, 1, 0, 0, 0, -1));
    vecs.push_back(mk(1, 0, 17, 3'd5, 1, 0, 0, 0, -1));
    vecs.push_back(mk(1, 0, 4,  3'd6, 0, 0, 0, 1, -1));
    vecs.push_back(mk(1, 0, 5,  3'd6, 0, 0, 0, 1, 2));
    vecs.push_back(mk(0, 0, 1,  3'd0, 0, 0, 0, 0, 0));
    // Bring-up, then brown-out in RUN with one successful retry
    vecs.push_back(mk(1, 1, 6,  3'd2, 1, 0, 0, 0, -1));
    vecs.push_back(mk(1, 1, 1,  3'd3, 1, 0, 0, 0, -1));
    vecs.push_back(mk(1, 1, 9,  3'd4, 1, 1, 1, 0, -1));
    vecs.push_back(mk(1, 0, 3,  3'd5, 1, 0, 0, 0, -1));
    vecs.push_back(mk(1, 0, 2,  3'd5, 1, 0, 0, 0, -1));
    vecs.push_back(mk(1, 1, 2,  3'd1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 5,  3'd2, 1, 0, 0, 0, -1));
    vecs.push_back(mk(1, 1, 1,  3'd3, 1, 0, 0, 0, -1));
    vecs.push_back(mk(1, 1, 9,  3'd4, 1, 1, 1, 0, 0));
    // Shut down, then abort during PWR_WAIT with the counter at 2
    vecs.push_back(mk(0, 1, 1,  3'd5, 1, 0, 0, 0, -1));
    vecs.push_back(mk(0, 1, 4,  3'd0, 0, 0, 0, 0, -1));
    vecs.push_back(mk(1, 1, 3,  3'd1, 0, 0, 0, 0, -1));
    vecs.push_back(mk(0, 1, 1,  3'd0, 0, 0, 0, 0, -1));
    vecs.push_back(mk(0, 1, 6,  3'd0, 0, 0, 0, 0, -1));

    // Reset values, including with en requested while reset is held
    @(negedge clk);
    compare("reset", 3'd0, 0, 0, 0, 0);
    en = 1'b1;
    repeat (3) @(negedge clk);
    compare("reset_en_held", 3'd0, 0, 0, 0, 0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(i, vecs[i]);
      if (vecs[i].rc >= 0) check_retry($sformatf("retry%0d", i), vecs[i].rc);
    end

    // Asynchronous reset while in RST_HOLD
    step(100, mk(1, 1, 7, 3'd3, 1, 0, 0, 0, -1));
    step(101, mk(1, 1, 3, 3'd3, 1, 0, 0, 0, -1));
    #2 rst_n = 1'b0;
    #1 compare("arst_rst_hold", 3'd0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(102, mk(1, 1, 1, 3'd1, 0, 0, 0, 0, -1));
    step(103, mk(1, 1, 5, 3'd2, 1, 0, 0, 0, -1));
    step(104, mk(1, 1, 1, 3'd3, 1, 0, 0, 0, -1));
    step(105, mk(1, 1, 9, 3'd4, 1, 1, 1, 0, -1));
    // Asynchronous reset while in RUN
    #2 rst_n = 1'b0;
    #1 compare("arst_run", 3'd0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(106, mk(0, 1, 3, 3'd0, 0, 0, 0, 0, -1));
    step(107, mk(1, 1, 1, 3'd1, 0, 0, 0, 0, -1));

    repeat (2) @(negedge clk);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL step%0d: expectation due at cycle %0d never compared", e.id, e.at);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
